// File: rtl/psum_acc_seq_if.sv
// ---------------------------------------------------------------------------
// psum_acc_seq_if
//   Bundles the signals around the partial-sum sequencer: the start/done
//   handshake with the core FSM, the psum SRAM read port, the SFP
//   (accumulate/ReLU unit) connection and the output SRAM write port.
//
//   master modport : the sequencer itself (drives the SRAM/SFP controls)
//   slave  modport : the environment (core FSM, SRAMs, SFP)
//
//   Handshake : start, psum_base, out_base -> ; busy, done <-
//   psum SRAM : psum_cen (active-low), psum_addr ->; psum_q <- (1-cycle latency)
//   SFP       : sfp_clr, acc, sfp_in ->; sfp_out <-
//   out SRAM  : out_wen (active-low), out_addr, out_d ->
// ---------------------------------------------------------------------------
interface psum_acc_seq_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11
);
  logic                     start;
  logic [addr_bw-1:0]       psum_base;
  logic [addr_bw-1:0]       out_base;
  logic                     busy;
  logic                     done;
  logic                     psum_cen;
  logic [addr_bw-1:0]       psum_addr;
  logic [psum_bw*col-1:0]   psum_q;
  logic                     sfp_clr;
  logic                     acc;
  logic [psum_bw*col-1:0]   sfp_in;
  logic [psum_bw*col-1:0]   sfp_out;
  logic                     out_wen;
  logic [addr_bw-1:0]       out_addr;
  logic [psum_bw*col-1:0]   out_d;

  modport master (
    input  start, psum_base, out_base, psum_q, sfp_out,
    output busy, done, psum_cen, psum_addr, sfp_clr, acc, sfp_in,
           out_wen, out_addr, out_d
  );

  modport slave (
    output start, psum_base, out_base, psum_q, sfp_out,
    input  busy, done, psum_cen, psum_addr, sfp_clr, acc, sfp_in,
           out_wen, out_addr, out_d
  );
endinterface

// File: rtl/psum_acc_seq.sv
// ---------------------------------------------------------------------------
// psum_acc_seq
//   Sequencer between the partial-sum SRAM and the accumulate/ReLU SFP.
//   For every output row o it clears the SFP, reads num_acc psum rows at
//   addresses psum_base + o + k*num_out (k = 0..num_acc-1, modulo 2^addr_bw),
//   strobes acc once per returned row, leaves one acc-low cycle for ReLU and
//   writes the SFP result to out_base + o.  Each output takes num_acc+4
//   cycles (CLR, RD x num_acc, DRAIN, RELU, WR); a single DONE cycle ends
//   the job.
//
//   Ports
//     clk     : clock, rising edge
//     reset   : synchronous, active-high
//     bus     : psum_acc_seq_if.master (handshake, psum SRAM, SFP, out SRAM)
//     perf_cycles [31:0] : only with ACC_PERF_EN; busy-cycle count of the
//                          last job, cleared on accepted start, saturating
//
//   Optional feature macro: ACC_PERF_EN
// ---------------------------------------------------------------------------
module psum_acc_seq #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int num_acc = 9,
  parameter int num_out = 16
) (
  input  logic           clk,
  input  logic           reset,
  psum_acc_seq_if.master bus
`ifdef ACC_PERF_EN
  ,
  output logic [31:0]    perf_cycles
`endif
);

  localparam int DW = psum_bw * col;
  localparam int KW = (num_acc > 1) ? $clog2(num_acc) : 1;
  localparam int OW = (num_out > 1) ? $clog2(num_out) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RD,
    S_DRAIN,
    S_RELU,
    S_WR,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [OW-1:0]      o_q, o_d;
  logic [KW-1:0]      k_q, k_d;
  logic [addr_bw-1:0] psum_base_q, psum_base_d;
  logic [addr_bw-1:0] out_base_q, out_base_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               psum_cen_q, psum_cen_d;
  logic               out_wen_q, out_wen_d;
  logic               acc_q, acc_d;
  logic               sfp_clr_q, sfp_clr_d;
  logic [addr_bw-1:0] psum_addr_q, psum_addr_d;
  logic [addr_bw-1:0] out_addr_q, out_addr_d;
  logic               start_acc;
  logic [DW-1:0]      rd_lanes;
  logic [DW-1:0]      wr_lanes;

  assign start_acc = (state_q == S_IDLE) && bus.start;

  always_comb begin
    state_d     = state_q;
    o_d         = o_q;
    k_d         = k_q;
    psum_base_d = psum_base_q;
    out_base_d  = out_base_q;
    done_d      = 1'b0;
    psum_cen_d  = 1'b1;
    out_wen_d   = 1'b1;
    sfp_clr_d   = 1'b0;
    // psum_q returns one cycle after each read, so acc simply trails RD.
    acc_d       = (state_q == S_RD);
    psum_addr_d = psum_addr_q;
    out_addr_d  = out_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          psum_base_d = bus.psum_base;
          out_base_d  = bus.out_base;
          o_d         = '0;
          sfp_clr_d   = 1'b1;
          state_d     = S_CLR;
        end
      end
      S_CLR: begin
        k_d         = '0;
        psum_cen_d  = 1'b0;
        psum_addr_d = psum_base_q + addr_bw'(o_q);
        state_d     = S_RD;
      end
      S_RD: begin
        if (k_q == KW'(num_acc - 1)) begin
          state_d = S_DRAIN;
        end else begin
          // Stepping by num_out replaces the k*num_out multiply; the add
          // wraps modulo 2^addr_bw like the direct formula.
          k_d         = k_q + KW'(1);
          psum_cen_d  = 1'b0;
          psum_addr_d = psum_addr_q + addr_bw'(num_out);
        end
      end
      S_DRAIN: begin
        state_d = S_RELU;
      end
      S_RELU: begin
        out_wen_d  = 1'b0;
        out_addr_d = out_base_q + addr_bw'(o_q);
        state_d    = S_WR;
      end
      S_WR: begin
        if (o_q == OW'(num_out - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          o_d       = o_q + OW'(1);
          sfp_clr_d = 1'b1;
          state_d   = S_CLR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      o_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      psum_cen_q  <= 1'b1;
      out_wen_q   <= 1'b1;
      acc_q       <= 1'b0;
      sfp_clr_q   <= 1'b0;
      psum_addr_q <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      k_q         <= k_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      psum_cen_q  <= psum_cen_d;
      out_wen_q   <= out_wen_d;
      acc_q       <= acc_d;
      sfp_clr_q   <= sfp_clr_d;
      psum_addr_q <= psum_addr_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // Job bases are plain data, only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    psum_base_q <= psum_base_d;
    out_base_q  <= out_base_d;
  end

  assign rd_lanes      = bus.psum_q;
  assign wr_lanes      = bus.sfp_out;
  assign bus.sfp_in    = rd_lanes;
  assign bus.out_d     = wr_lanes;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.psum_cen  = psum_cen_q;
  assign bus.psum_addr = psum_addr_q;
  assign bus.sfp_clr   = sfp_clr_q;
  assign bus.acc       = acc_q;
  assign bus.out_wen   = out_wen_q;
  assign bus.out_addr  = out_addr_q;

`ifdef ACC_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_psum_acc_seq.sv
module tb_psum_acc_seq;
  localparam int PBW = 16;
  localparam int COL = 8;
  localparam int ABW = 11;
  localparam int DW  = PBW * COL;

  // Read-address sequences for the num_acc=2 / num_out=4 instance.
  localparam logic [ABW-1:0] EXP_B0 [8] = '{11'h7F8, 11'h7FC, 11'h7F9, 11'h7FD,
                                             11'h7FA, 11'h7FE, 11'h7FB, 11'h7FF};
  localparam logic [ABW-1:0] EXP_B1 [8] = '{11'h7FE, 11'h002, 11'h7FF, 11'h003,
                                             11'h000, 11'h004, 11'h001, 11'h005};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  psum_acc_seq_if #(.psum_bw(PBW), .col(COL), .addr_bw(ABW)) a_if ();
  psum_acc_seq_if #(.psum_bw(PBW), .col(COL), .addr_bw(ABW)) b_if ();

`ifdef ACC_PERF_EN
  logic [31:0] perf_a, perf_b;
  logic [31:0] perf_c1;
`endif

  psum_acc_seq #(.psum_bw(PBW), .col(COL), .addr_bw(ABW), .num_acc(9), .num_out(16)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (a_if)
`ifdef ACC_PERF_EN
    ,
    .perf_cycles(perf_a)
`endif
  );

  psum_acc_seq #(.psum_bw(PBW), .col(COL), .addr_bw(ABW), .num_acc(2), .num_out(4)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (b_if)
`ifdef ACC_PERF_EN
    ,
    .perf_cycles(perf_b)
`endif
  );

  // psum SRAM (1-cycle read latency) and SFP models for instance A
  logic [DW-1:0]          pmem [0:2047];
  logic                   relu_en;
  logic signed [PBW-1:0]  sfp_acc [COL];

  always @(posedge clk) begin
    if (!a_if.psum_cen) a_if.psum_q <= pmem[a_if.psum_addr];
  end

  always @(posedge clk) begin
    for (int l = 0; l < COL; l++) begin
      if (a_if.sfp_clr) sfp_acc[l] <= '0;
      else if (a_if.acc) sfp_acc[l] <= sfp_acc[l] + $signed(a_if.sfp_in[l*PBW +: PBW]);
      else if (relu_en && (sfp_acc[l] < 0)) sfp_acc[l] <= '0;
    end
  end

  always_comb begin
    a_if.sfp_out = '0;
    for (int l = 0; l < COL; l++) a_if.sfp_out[l*PBW +: PBW] = sfp_acc[l];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [PBW-1:0] v);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < COL; l++) r[l*PBW +: PBW] = v;
    return r;
  endfunction

  task automatic fill(input bit neg);
    for (int a = 0; a < 2048; a++) pmem[a] = neg ? rep(16'hFFFB) : rep(PBW'(a));
  endtask

  logic [DW-1:0]  wr_data [32];
  logic [ABW-1:0] wr_addr [32];
  logic [ABW-1:0] baddr   [16];

  // Runs one job on instance A; cycle 1 is the cycle after the start edge.
  task automatic run_a(input logic [ABW-1:0] ob, input int restart_at,
                       output int done_cyc, output int nwr, output int nacc, output int nbad);
    int cyc;
    done_cyc = -1; nwr = 0; nacc = 0; nbad = 0;
    @(negedge clk);
    a_if.psum_base = '0; a_if.out_base = ob; a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    cyc = 1;
    while (cyc < 1000) begin
`ifdef ACC_PERF_EN
      if (cyc == 1) perf_c1 = perf_a;
`endif
      if (!a_if.out_wen) begin
        if (nwr < 32) begin wr_data[nwr] = a_if.out_d; wr_addr[nwr] = a_if.out_addr; end
        nwr++;
      end
      if (a_if.acc) nacc++;
      if (!a_if.busy) nbad++;
      if (!a_if.psum_cen && !a_if.out_wen) nbad++;
      if (a_if.sfp_clr && a_if.acc) nbad++;
      if (a_if.done) begin done_cyc = cyc; break; end
      @(negedge clk);
      cyc++;
      a_if.start = (cyc == restart_at);
    end
    a_if.start = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_b(input logic [ABW-1:0] pb, output int n, output int dc);
    @(negedge clk);
    b_if.psum_base = pb; b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    n = 0; dc = -1;
    for (int c = 1; c < 200; c++) begin
      if (!b_if.psum_cen) begin
        if (n < 16) baddr[n] = b_if.psum_addr;
        n++;
      end
      if (b_if.done) begin dc = c; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "time limit");
  end

  initial begin
    int dc, nwr, nacc, nbad, nb, found;
    reset = 1'b1;
    relu_en = 1'b0;
    a_if.start = 1'b0; a_if.psum_base = '0; a_if.out_base = '0;
    b_if.start = 1'b0; b_if.psum_base = '0; b_if.out_base = '0;
    b_if.psum_q = '0; b_if.sfp_out = '0;
    fill(1'b0);
    repeat (3) @(negedge clk);

    chk("rst_busy", a_if.busy, 0);
    chk("rst_done", a_if.done, 0);
    chk("rst_psum_cen", a_if.psum_cen, 1);
    chk("rst_out_wen", a_if.out_wen, 1);
    chk("rst_acc", a_if.acc, 0);
    chk("rst_sfp_clr", a_if.sfp_clr, 0);
    chk("rst_psum_addr", a_if.psum_addr, 0);
    chk("rst_out_addr", a_if.out_addr, 0);
`ifdef ACC_PERF_EN
    chk("rst_perf", perf_a, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Job 1: lane value = address, with an ignored start pulse at cycle 50
    run_a(11'h000, 50, dc, nwr, nacc, nbad);
    chk("j1_done_cycle", dc, 209);
    chk("j1_writes", nwr, 16);
    chk("j1_acc_cycles", nacc, 144);
    chk("j1_busy_invariants", nbad, 0);
    chk("j1_idle_after", a_if.busy, 0);
    for (int o = 0; o < 16; o++) begin
      chk($sformatf("j1_row%0d_data", o), wr_data[o], rep(PBW'(9*o + 576)));
      chk($sformatf("j1_row%0d_addr", o), wr_addr[o], o);
    end
`ifdef ACC_PERF_EN
    chk("j1_perf", perf_a, 209);
`endif

    // Job 2: all lanes -5 with ReLU, output base 0x20
    fill(1'b1);
    relu_en = 1'b1;
    run_a(11'h020, 0, dc, nwr, nacc, nbad);
`ifdef ACC_PERF_EN
    chk("j2_perf_cleared", perf_c1, 0);
`endif
    chk("j2_done_cycle", dc, 209);
    chk("j2_writes", nwr, 16);
    chk("j2_busy_invariants", nbad, 0);
    for (int o = 0; o < 16; o++) begin
      chk($sformatf("j2_row%0d_data", o), wr_data[o], '0);
      chk($sformatf("j2_row%0d_addr", o), wr_addr[o], 'h20 + o);
    end

    // Job 3: reset during the RD phase of output 3
    fill(1'b0);
    relu_en = 1'b0;
    @(negedge clk);
    a_if.psum_base = '0; a_if.out_base = '0; a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    found = 0; nwr = 0;
    for (int c = 0; c < 400; c++) begin
      if (!a_if.out_wen) nwr++;
      if (nwr == 3 && !a_if.psum_cen && a_if.acc) begin found = 1; break; end
      @(negedge clk);
    end
    chk("j3_reached_rd3", found, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("j3_rst_busy", a_if.busy, 0);
    chk("j3_rst_psum_cen", a_if.psum_cen, 1);
    chk("j3_rst_out_wen", a_if.out_wen, 1);
    chk("j3_rst_acc", a_if.acc, 0);
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (!a_if.out_wen || a_if.busy || !a_if.psum_cen) nb++;
    end
    chk("j3_quiet_after_rst", nb, 0);
    run_a(11'h000, 0, dc, nwr, nacc, nbad);
    chk("j3_fresh_done_cycle", dc, 209);
    chk("j3_fresh_writes", nwr, 16);
    chk("j3_fresh_row0", wr_data[0], rep(16'd576));
    chk("j3_fresh_row15", wr_data[15], rep(16'd711));

    // Instance B: strided read addresses, including wrap past 0x7FF
    run_b(11'h7F8, nb, dc);
    chk("b0_reads", nb, 8);
    chk("b0_done_cycle", dc, 25);
    for (int i = 0; i < 8; i++) chk($sformatf("b0_addr%0d", i), baddr[i], EXP_B0[i]);
`ifdef ACC_PERF_EN
    chk("b0_perf", perf_b, 25);
`endif
    run_b(11'h7FE, nb, dc);
    chk("b1_reads", nb, 8);
    chk("b1_done_cycle", dc, 25);
    for (int i = 0; i < 8; i++) chk($sformatf("b1_addr%0d", i), baddr[i], EXP_B1[i]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/psum_acc_seq.md
Name: psum_acc_seq

Overview:
- Sequencer that feeds the accumulate/ReLU special-function unit (SFP) from the partial-sum SRAM and writes the finished outputs to the output SRAM.
- For each output row it reads num_acc partial-sum rows at a stride and presents them one per cycle with an accumulate strobe.
- It then holds the strobe low for one ReLU cycle and writes the SFP result back.
- Sits between the psum memory and the SFP, under control of the top-level core FSM through a start/done handshake.

Parameters:
- psum_bw, 16, bits per partial-sum lane
- col, 8, lanes per row
- addr_bw, 11, SRAM address width
- num_acc, 9, partial sums accumulated per output (kernel positions); >=1
- num_out, 16, output rows per job; >=1

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle job request; honoured only in IDLE
- psum_base  in  addr_bw  psum SRAM base address, latched on accepted start
- out_base  in  addr_bw  output SRAM base address, latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end
- psum_cen  out  1  psum SRAM chip enable, active-low
- psum_addr  out  addr_bw  psum SRAM read address
- psum_q  in  psum_bw*col  psum SRAM read data, valid 1 cycle after the cen=0 cycle
- sfp_clr  out  1  one-cycle clear to SFP (drives its reset)
- acc  out  1  accumulate strobe to SFP (its acc_q)
- sfp_in  out  psum_bw*col  data to SFP; equals psum_q combinationally
- sfp_out  in  psum_bw*col  SFP result
- out_wen  out  1  output SRAM write enable, active-low
- out_addr  out  addr_bw  output SRAM write address
- out_d  out  psum_bw*col  output SRAM write data; equals sfp_out combinationally

Behaviour:
- Reset values: busy=0, done=0, psum_cen=1, out_wen=1, acc=0, sfp_clr=0, psum_addr=0, out_addr=0. Counters o and k are 0; state is IDLE.
- Reset mid-job returns to IDLE on the next edge; the partial job is abandoned and no write is issued.
- States:
  - IDLE: start=1 latches the bases, clears o, goes to CLR. start in any other state is ignored.
  - CLR: sfp_clr=1 for one cycle; k=0; goes to RD.
  - RD: psum_cen=0, psum_addr = psum_base + o + k*num_out (computed modulo 2^addr_bw, wrap allowed); k++. After the k=num_acc-1 read, goes to DRAIN.
  - DRAIN: one cycle, no read; delivers the final acc.
  - RELU: one cycle, acc=0; the SFP applies ReLU at this edge.
  - WR: out_wen=0, out_addr = out_base + o. If o==num_out-1, goes to DONE; otherwise o++ and goes to CLR.
  - DONE: done=1 for one cycle, then IDLE.
- acc is registered: it is high exactly in the cycle after each RD cycle, aligned with valid psum_q. This gives exactly num_acc acc cycles per output.
- In the first RD cycle acc=0; the SFP applies ReLU to its cleared value, which is harmless.
- Timing per output: num_acc+4 cycles. done is high num_out*(num_acc+4)+1 cycles after the accepted start edge.
- Never: psum_cen=0 and out_wen=0 in the same cycle; sfp_clr and acc high together.
- num_acc=1: RD lasts one cycle, then DRAIN.

Optional Feature:
- Macro: ACC_PERF_EN
- Defined: adds output perf_cycles [31:0]. It is cleared on an accepted start and increments each cycle while busy=1, saturating at 0xFFFFFFFF. It holds its value after done until the next start. Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- num_acc=9, num_out=16, bases 0; psum row at address a has every lane = a. Pulse start -> out row o, every lane = sum over k of (o+16k) = 9o+576. done is asserted 209 cycles after the start edge.
- With an SFP using relu=1, preload psum rows with lane value -5 -> every written out lane = 0. Check busy=1 from the cycle after start until done; one out_wen=0 per output.
- psum_base=0x7F8, num_out=4, num_acc=2 -> read addresses 0x7F8,0x7FC,0x7F9,0x7FD,... and wrap past 0x7FF to 0x000 as computed.
- Pulse start again at cycle 50 of a job -> ignored; write count and done timing unchanged.
- Assert reset in the RD state of output 3 -> next cycle busy=0, psum_cen=1, out_wen=1, acc=0. A fresh start then completes normally.
- ACC_PERF_EN defined, num_acc=9, num_out=16 -> perf_cycles=209 after done; it clears to 0 on the next start.
